fp_req_init: RTL and testbench
==============================

FP_REQ_INIT -- requirements
Module: fp_req_init

Interface
REQ-001 SHALL have parameter EMSB, default 7, meaning exponent MSB index.
REQ-002 SHALL have parameter FMSB, default 22, meaning fraction MSB index; word width W = EMSB+FMSB+3, default 32.
REQ-003 SHALL have parameter TMO, default 255, meaning timeout in clk cycles spent in WAIT; legal range 4..65535.
REQ-004 SHALL have port clk, input, 1, meaning sole clock, rising edge.
REQ-005 SHALL have port rstn, input, 1, meaning reset, asynchronous assert, active-low.
REQ-006 SHALL have port enable, input, 1, meaning permits acceptance of new operands.
REQ-007 SHALL have port in_valid, input, 1, meaning upstream operand pair valid.
REQ-008 SHALL have port in_ready, output, 1, meaning operand pair accepted this edge when in_valid is also high.
REQ-009 SHALL have ports in_data_1 and in_data_2, input, W each, meaning operands in {sign, exponent, fraction} order.
REQ-010 SHALL have port req, output, 1, meaning two-phase request to fp_add; each toggle is one transaction.
REQ-011 SHALL have ports tx_data_1 and tx_data_2, output, W each, meaning registered operands driven to the responder's rx_data_1 and rx_data_2.
REQ-012 SHALL have port ack, input, 1, meaning responder two-phase acknowledge, asynchronous to clk.
REQ-013 SHALL have port rx_data, input, W, meaning responder result, stable while ack equals req.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, W) and out_err (output, 1), meaning the result channel and timeout flag.
REQ-015 SHALL have port txn_cnt, output, 16, meaning completed-transaction count.

Function
REQ-016 SHALL synchronize ack through two flops, ack_m then ack_s; no other logic SHALL use raw ack.
REQ-017 SHALL implement three states: IDLE, WAIT and DONE.
REQ-018 SHALL drive in_ready = (state==IDLE) && enable && (ack_s==req), combinationally.
REQ-019 On an IDLE edge with in_valid && in_ready, SHALL register tx_data_1/2 from in_data_1/2, toggle req on the same edge, clear the timer and enter WAIT.
REQ-020 SHALL hold tx_data_1/2 constant from the launch edge until the next accepted pair (bundled data).
REQ-021 In WAIT, on an edge with ack_s==req, SHALL capture rx_data into out_data, set out_valid=1 and out_err=0, increment txn_cnt, and enter DONE.
REQ-022 Latency: out_valid SHALL rise on the third rising clk edge at or after the ack transition.
REQ-023 In WAIT, the timer SHALL increment each cycle; when it reaches TMO-1 without a match, the block SHALL set out_valid=1, out_err=1 and out_data to quiet NaN (sign 0, exponent all ones, fraction MSB 1, rest 0; 0x7FC00000 at default width), and enter DONE, with txn_cnt unchanged.
REQ-024 If the match and the timeout occur on the same edge, the match SHALL win.
REQ-025 In DONE, out_valid, out_data and out_err SHALL stay stable; on an edge with out_ready=1, out_valid SHALL fall and the state SHALL return to IDLE.
REQ-026 After a timeout, a late ack SHALL only re-enable in_ready via REQ-018; its data SHALL be discarded.
REQ-027 Deasserting enable SHALL NOT abort a transaction in WAIT or DONE; it SHALL only block new acceptance.
REQ-028 txn_cnt SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-029 While rstn=0, the block SHALL hold: state=IDLE, req=0, ack_m=ack_s=0, tx_data_1/2=0, out_valid=0, out_err=0, out_data=0, txn_cnt=0, timer=0.
REQ-030 On reset mid-transaction, the block SHALL NOT re-issue; in_ready SHALL stay low until ack_s equals 0.
REQ-031 On reset release, the block SHALL change no state before the first rising edge with rstn=1.

Verification
REQ-032 Bench SHALL cover: in 0x3F800000/0x40000000, responder toggles ack 5 cycles after req with rx_data=0x40400000 -> req 0->1, out_valid rises 3 edges after ack, out_data=0x40400000, out_err=0, txn_cnt=1.
REQ-033 Bench SHALL cover: 300 back-to-back pairs with out_ready tied high and random 1-20 cycle responder delay -> results in order, req toggles 300 times, txn_cnt=300.
REQ-034 Bench SHALL cover: responder never acks -> out_valid at WAIT cycle TMO-1, out_data=0x7FC00000, out_err=1, txn_cnt unchanged; a late ack then raises in_ready.
REQ-035 Bench SHALL cover: out_ready held low 50 cycles -> out_data and out_valid stable, in_ready=0 throughout.
REQ-036 Bench SHALL cover: rstn pulsed low while in WAIT -> all outputs reset immediately; a later ack toggle to 1 keeps in_ready low until ack returns to 0.
REQ-037 Bench SHALL cover: enable dropped one cycle after accept -> the transaction completes, and no new accept occurs until enable=1.

Source files
------------

// File: rtl/fp_req_init.sv
// Requester side of a two-phase bundled-data link to fp_add: launches operand pairs, returns results on valid/ready.
// Latency: result 3 clk edges after the ack transition; WAIT gives up with quiet NaN after TMO cycles.
// Backpressure: in_ready only in IDLE with req/ack settled; DONE holds the result until out_ready.
module fp_req_init #(
    parameter int EMSB = 7,
    parameter int FMSB = 22,
    parameter int TMO  = 255,
    localparam int W   = EMSB + FMSB + 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         enable,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data_1,
    input  logic [W-1:0] in_data_2,
    output logic         req,
    output logic [W-1:0] tx_data_1,
    output logic [W-1:0] tx_data_2,
    input  logic         ack,
    input  logic [W-1:0] rx_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err,
    output logic [15:0]  txn_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [15:0]  TMO_LAST = 16'(TMO - 1);
    localparam logic [W-1:0] QNAN     = {1'b0, {(EMSB + 1){1'b1}}, 1'b1, {FMSB{1'b0}}};

    logic [1:0]   state_q, state_d;
    logic         req_q, req_d;
    logic         ack_m_q, ack_m_d;
    logic         ack_s_q, ack_s_d;
    logic [W-1:0] tx_data_1_q, tx_data_1_d;
    logic [W-1:0] tx_data_2_q, tx_data_2_d;
    logic         out_valid_q, out_valid_d;
    logic         out_err_q, out_err_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [15:0]  txn_cnt_q, txn_cnt_d;
    logic [15:0]  timer_q, timer_d;
    logic         link_idle;
    logic         accept;

    // Link is quiescent once the synchronized ack has caught up with req.
    assign link_idle = (ack_s_q == req_q);
    assign in_ready  = (state_q == S_IDLE) && enable && link_idle;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        ack_m_d     = ack;
        ack_s_d     = ack_m_q;
        tx_data_1_d = tx_data_1_q;
        tx_data_2_d = tx_data_2_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        out_data_d  = out_data_q;
        txn_cnt_d   = txn_cnt_q;
        timer_d     = timer_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tx_data_1_d = in_data_1;
                    tx_data_2_d = in_data_2;
                    req_d       = ~req_q;
                    timer_d     = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // A match on the timeout edge still counts as a real result.
                if (link_idle) begin
                    out_data_d  = rx_data;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b0;
                    txn_cnt_d   = txn_cnt_q + 16'd1;
                    state_d     = S_DONE;
                end else if (timer_q == TMO_LAST) begin
                    out_data_d  = QNAN;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            ack_m_q     <= 1'b0;
            ack_s_q     <= 1'b0;
            tx_data_1_q <= '0;
            tx_data_2_q <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= '0;
            txn_cnt_q   <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ack_m_q     <= ack_m_d;
            ack_s_q     <= ack_s_d;
            tx_data_1_q <= tx_data_1_d;
            tx_data_2_q <= tx_data_2_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_data_q  <= out_data_d;
            txn_cnt_q   <= txn_cnt_d;
            timer_q     <= timer_d;
        end
    end

    assign req       = req_q;
    assign tx_data_1 = tx_data_1_q;
    assign tx_data_2 = tx_data_2_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign out_data  = out_data_q;
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_fp_req_init.sv
// Bench for fp_req_init: directed transactions, a scripted fp_add responder, and a scoreboard monitor on the result channel.
module tb_fp_req_init;
    localparam int W   = 32;
    localparam int TMO = 255;
    localparam logic [W-1:0] QNAN = 32'h7FC0_0000;

    localparam int K_NORMAL = 0;
    localparam int K_TMO    = 1;
    localparam int K_NONE   = 2;

    typedef struct packed {
        logic [W-1:0] d;
        logic         e;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] op1;
        logic [W-1:0] op2;
        logic [W-1:0] res;
    } resp_t;

    logic         clk = 1'b0;
    logic         rstn, enable, in_valid, in_ready, req, ack;
    logic         out_valid, out_ready, out_err;
    logic [W-1:0] in_data_1, in_data_2, tx_data_1, tx_data_2, rx_data, out_data;
    logic [15:0]  txn_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int launch_cyc = 0;
    int exp_txn = 0;
    int req_toggles = 0;
    logic req_last = 1'b0;

    logic resp_on, resp_rand, man_mode, man_ack;
    int   resp_dly;

    exp_t  exp_q[$];
    resp_t resp_q[$];

    fp_req_init #(.EMSB(7), .FMSB(22), .TMO(TMO)) dut (
        .clk(clk), .rstn(rstn), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data_1(in_data_1), .in_data_2(in_data_2),
        .req(req), .tx_data_1(tx_data_1), .tx_data_2(tx_data_2),
        .ack(ack), .rx_data(rx_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Responder: answers each req toggle after a delay, checking the bundled operands.
    initial begin
        resp_t r;
        int    d;
        ack = 1'b0;
        rx_data = '0;
        forever begin
            @(posedge clk); #1;
            if (man_mode) begin
                ack = man_ack;
                rx_data = 32'hDEAD_BEEF;
            end else if (resp_on && rstn && (req !== ack)) begin
                if (resp_q.size() == 0) begin
                    fail_now("responder_unexpected_req");
                    ack = req;
                end else begin
                    r = resp_q.pop_front();
                    check("tx_data_1", tx_data_1, r.op1);
                    check("tx_data_2", tx_data_2, r.op2);
                    d = resp_rand ? int'($urandom_range(1, 20)) : resp_dly;
                    repeat (d) @(posedge clk);
                    #2;
                    rx_data = r.res;
                    ack = req;
                end
            end
        end
    end

    // Monitor: scoreboard pop on every result handshake, plus req toggle counting.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_err", {31'd0, out_err}, {31'd0, e.e});
                end
            end
            if (req !== req_last) begin
                req_toggles++;
                req_last = req;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input int kind);
        int n = 0;
        if (kind == K_NORMAL) begin
            resp_q.push_back('{a, b, r});
            exp_q.push_back('{r, 1'b0});
            exp_txn++;
        end else if (kind == K_TMO) begin
            exp_q.push_back('{QNAN, 1'b1});
        end
        in_data_1 = a;
        in_data_2 = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            fail_now("accept_wait");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        launch_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) fail_now("out_valid_wait");
        lat = cyc - launch_cyc;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) fail_now("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int tog0;
        rstn = 1'b0; enable = 1'b1; in_valid = 1'b0;
        in_data_1 = '0; in_data_2 = '0; out_ready = 1'b1;
        resp_on = 1'b1; resp_rand = 1'b0; resp_dly = 5;
        man_mode = 1'b0; man_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_tx1", tx_data_1, 32'd0);
        check("rst_tx2", tx_data_2, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_txn_cnt", {16'd0, txn_cnt}, 32'd0);
        @(negedge clk) rstn = 1'b1;
        #1;
        check("release_req", {31'd0, req}, 32'd0);
        @(posedge clk); #1;

        // Single directed transaction, 5-cycle responder
        send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, K_NORMAL);
        check("t1_req_toggled", {31'd0, req}, 32'd1);
        wait_valid(lat);
        check("t1_latency", lat, 32'd8);
        drain();
        check("t1_txn_cnt", {16'd0, txn_cnt}, 32'd1);

        // 300 back-to-back with random responder delay
        resp_rand = 1'b1;
        tog0 = req_toggles;
        for (int i = 0; i < 300; i++) begin
            send(32'h3F80_0000 + i, 32'h4000_0000 ^ i, 32'h4100_0000 + 3 * i, K_NORMAL);
        end
        drain();
        resp_rand = 1'b0;
        check("t2_req_toggles", req_toggles - tog0, 32'd300);
        check("t2_txn_cnt", {16'd0, txn_cnt}, exp_txn);

        // Silent responder: timeout path, then a late ack
        resp_on = 1'b0;
        send(32'h1111_1111, 32'h2222_2222, '0, K_TMO);
        wait_valid(lat);
        check("t3_tmo_cycles", lat, TMO);
        check("t3_qnan", out_data, QNAN);
        check("t3_err", {31'd0, out_err}, 32'd1);
        drain();
        check("t3_txn_unchanged", {16'd0, txn_cnt}, exp_txn);
        @(negedge clk);
        check("t3_in_ready_blocked", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        man_mode = 1'b1;
        man_ack = req;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t3_late_ack_ready", {31'd0, in_ready}, 32'd1);
        check("t3_late_no_output", {31'd0, out_valid}, 32'd0);
        check("t3_late_txn", {16'd0, txn_cnt}, exp_txn);
        @(posedge clk); #1;
        man_mode = 1'b0;
        resp_on = 1'b1;
        resp_dly = 3;

        // Result held under out_ready=0 for 50 cycles
        out_ready = 1'b0;
        send(32'h40A0_0000, 32'h4040_0000, 32'h4100_0000, K_NORMAL);
        wait_valid(lat);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t4_hold_data", out_data, 32'h4100_0000);
            check("t4_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        check("t4_txn_cnt", {16'd0, txn_cnt}, exp_txn);

        // enable dropped one cycle after accept
        resp_dly = 4;
        send(32'hC000_0000, 32'h3F00_0000, 32'hBFC0_0000, K_NORMAL);
        @(posedge clk); #1;
        enable = 1'b0;
        drain();
        check("t5_completed", {16'd0, txn_cnt}, exp_txn);
        tog0 = req_toggles;
        in_data_1 = 32'h4120_0000;
        in_data_2 = 32'h4130_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_blocked_ready", {31'd0, in_ready}, 32'd0);
        end
        check("t5_no_launch", req_toggles - tog0, 32'd0);
        @(posedge clk); #1;
        enable = 1'b1;
        send(32'h4120_0000, 32'h4130_0000, 32'h41A8_0000, K_NORMAL);
        drain();
        check("t5_resumed", {16'd0, txn_cnt}, exp_txn);

        // Reset while waiting, then a stale ack from the old transaction
        if (req) begin
            send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, K_NORMAL);
            drain();
        end
        resp_on = 1'b0;
        send(32'h1234_5678, 32'h9ABC_DEF0, '0, K_NONE);
        repeat (5) @(posedge clk);
        @(negedge clk) rstn = 1'b0;
        #1;
        exp_txn = 0;
        check("t6_rst_req", {31'd0, req}, 32'd0);
        check("t6_rst_tx1", tx_data_1, 32'd0);
        check("t6_rst_tx2", tx_data_2, 32'd0);
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_err", {31'd0, out_err}, 32'd0);
        check("t6_rst_data", out_data, 32'd0);
        check("t6_rst_txn", {16'd0, txn_cnt}, 32'd0);
        check("t6_rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        man_mode = 1'b1;
        man_ack = 1'b1;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_stale_ready", {31'd0, in_ready}, 32'd0);
            check("t6_stale_req", {31'd0, req}, 32'd0);
            check("t6_stale_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        man_ack = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_ack_back_ready", {31'd0, in_ready}, 32'd1);
        man_mode = 1'b0;

        check("end_exp_q_empty", exp_q.size(), 32'd0);
        check("end_resp_q_empty", resp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
